// File: rtl/servo_pwm_if.sv
// servo_pwm_if
//   Command/status bundle between the upstream position controller and
//   servo_pwm_gen.
//   master : drives position/pos_valid, observes the PWM status outputs
//   slave  : servo_pwm_gen side
//   Signals:
//     position     [7:0] commanded servo position (degrees)
//     pos_valid          qualifies position for one cycle
//     pwm_out            registered servo pulse
//     frame_start        one-cycle strobe on the first cycle of each frame
//     active_pos   [7:0] position governing the current frame
//     clamp_active       current frame's command exceeded MAX_POS
interface servo_pwm_if;
    logic [7:0] position;
    logic       pos_valid;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] active_pos;
    logic       clamp_active;

    modport master (
        output position, pos_valid,
        input  pwm_out, frame_start, active_pos, clamp_active
    );

    modport slave (
        input  position, pos_valid,
        output pwm_out, frame_start, active_pos, clamp_active
    );
endinterface

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Fixed-period servo PWM generator. Position commands are latched at any
//   time but only applied on frame boundaries, so pulses are never glitched.
//   Optional feature macro: SERVO_SLEW_LIMIT_EN (limits active_pos movement
//   to SLEW_STEP per frame).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    servo_pwm_if.slave (position, pos_valid in; pwm_out,
//            frame_start, active_pos, clamp_active out)
//
//   state | meaning
//   RUN   | only state; prescaler and frame counter free-run, reset parks
//         | both on their last count so the first edge is a frame boundary
module servo_pwm_gen #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned FRAME_US     = 20000,
    parameter int unsigned MIN_PULSE_US = 1000,
    parameter int unsigned MAX_PULSE_US = 2000,
    parameter int unsigned MAX_POS      = 180,
    parameter int unsigned CENTER_POS   = 90,
    parameter int unsigned SLEW_STEP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    servo_pwm_if.slave bus
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int          PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam logic [31:0] SPAN  = 32'(MAX_PULSE_US - MIN_PULSE_US);

    generate
        if (DIV < 2 || (CLK_FREQ_HZ % 1_000_000) != 0 || FRAME_US < 2 ||
            MAX_POS == 0 || MAX_POS > 255 || CENTER_POS > MAX_POS ||
            MAX_PULSE_US < MIN_PULSE_US || SLEW_STEP == 0 || SLEW_STEP > 255)
        begin : g_bad_cfg
            $error("servo_pwm_gen: illegal parameter set");
        end
    endgenerate

    logic [PRE_W-1:0] r_pre_cnt;
    logic [US_W-1:0]  r_us_cnt;
    logic [7:0]       r_pending;
    logic [7:0]       r_active;
    logic             r_clamp;
    logic             r_frame_start;
    logic             r_pwm;
    logic [31:0]      r_pulse_us;

    logic             w_pre_wrap;
    logic             w_us_wrap;
    logic             w_boundary;
    logic [PRE_W-1:0] w_pre_next;
    logic [US_W-1:0]  w_us_next;
    logic [7:0]       w_cmd;
    logic             w_over;
    logic [7:0]       w_target;
    logic [7:0]       w_slewed;
    logic [7:0]       w_active_next;
    logic [31:0]      w_pulse_next;

    always_comb begin
        w_pre_wrap = (r_pre_cnt == PRE_W'(DIV - 1));
        w_us_wrap  = (r_us_cnt == US_W'(FRAME_US - 1));
        w_boundary = w_pre_wrap && w_us_wrap;

        w_pre_next = w_pre_wrap ? '0 : r_pre_cnt + PRE_W'(1);
        w_us_next  = r_us_cnt;
        if (w_pre_wrap) begin
            w_us_next = w_us_wrap ? '0 : r_us_cnt + US_W'(1);
        end

        // A command arriving on the boundary edge itself governs the new frame.
        w_cmd    = bus.pos_valid ? bus.position : r_pending;
        w_over   = (w_cmd > 8'(MAX_POS));
        w_target = w_over ? 8'(MAX_POS) : w_cmd;

`ifdef SERVO_SLEW_LIMIT_EN
        w_slewed = w_target;
        if (w_target > r_active) begin
            if ((w_target - r_active) > 8'(SLEW_STEP)) begin
                w_slewed = r_active + 8'(SLEW_STEP);
            end
        end else if ((r_active - w_target) > 8'(SLEW_STEP)) begin
            w_slewed = r_active - 8'(SLEW_STEP);
        end
`else
        w_slewed = w_target;
`endif

        w_active_next = w_boundary ? w_slewed : r_active;
        w_pulse_next  = r_pulse_us;
        if (w_boundary) begin
            w_pulse_next = 32'(MIN_PULSE_US) +
                           (32'(w_slewed) * SPAN) / 32'(MAX_POS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt     <= PRE_W'(DIV - 1);
            r_us_cnt      <= US_W'(FRAME_US - 1);
            r_pending     <= 8'(CENTER_POS);
            r_active      <= 8'(CENTER_POS);
            r_clamp       <= 1'b0;
            r_frame_start <= 1'b0;
            r_pwm         <= 1'b0;
            r_pulse_us    <= 32'(MIN_PULSE_US);
        end else begin
            r_pre_cnt     <= w_pre_next;
            r_us_cnt      <= w_us_next;
            r_frame_start <= w_boundary;
            r_active      <= w_active_next;
            r_pulse_us    <= w_pulse_next;
            // Registered compare against next-state values puts the rising
            // edge of the pulse on the boundary edge itself.
            r_pwm         <= (32'(w_us_next) < w_pulse_next);
            if (bus.pos_valid) begin
                r_pending <= bus.position;
            end
            if (w_boundary) begin
                r_clamp <= w_over;
            end
        end
    end

    assign bus.pwm_out      = r_pwm;
    assign bus.frame_start  = r_frame_start;
    assign bus.active_pos   = r_active;
    assign bus.clamp_active = r_clamp;

endmodule
